// File: rtl/score_display.sv
// score_display: converts the binary score (0..99) into two BCD digits with a
// sequential shift-add-3 engine and drives a two-digit multiplexed
// seven-segment display. Values above 99 are shown as "--".
module score_display #(
    parameter int unsigned BW      = 7,
    parameter int unsigned MUX_DIV = 1000
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic [BW-1:0] value_i,
    output logic [6:0]    seg_o,
    output logic [1:0]    dig_sel_o,
    output logic          ovf_o,
    output logic          busy_o
);

    localparam int unsigned   CW       = $clog2(BW);
    localparam int unsigned   RW       = $clog2(MUX_DIV);
    localparam logic [CW-1:0] BIT_LAST = CW'(BW - 1);
    localparam logic [RW-1:0] REF_LAST = RW'(MUX_DIV - 1);
    localparam logic [6:0]    DASH     = 7'h40;
    localparam logic [6:0]    BLANK    = 7'h00;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        LOAD
    } state_t;

    state_t        state_q;
    logic [BW-1:0] last_q;
    logic [BW-1:0] shift_q;
    logic          force_q;
    logic          ovf_pend_q;
    logic [CW-1:0] bit_q;
    logic [3:0]    tens_w;
    logic [3:0]    ones_w;
    logic [3:0]    tens_q;
    logic [3:0]    ones_q;
    logic          ovf_q;
    logic          valid_q;
    logic [RW-1:0] ref_q;
    logic          phase_q;
    logic [6:0]    seg_q;
    logic [1:0]    dig_q;

    logic          value_ovf;
    logic [3:0]    tens_adj;
    logic [3:0]    ones_adj;
    logic [6:0]    slot_glyph;

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'd0:    glyph = 7'h3F;
            4'd1:    glyph = 7'h06;
            4'd2:    glyph = 7'h5B;
            4'd3:    glyph = 7'h4F;
            4'd4:    glyph = 7'h66;
            4'd5:    glyph = 7'h6D;
            4'd6:    glyph = 7'h7D;
            4'd7:    glyph = 7'h07;
            4'd8:    glyph = 7'h7F;
            4'd9:    glyph = 7'h6F;
            default: glyph = BLANK;
        endcase
    endfunction

    assign value_ovf = (32'(value_i) > 32'd99);

    // Add-3 correction of each BCD nibble ahead of the next shift
    always_comb begin
        tens_adj = (tens_w >= 4'd5) ? tens_w + 4'd3 : tens_w;
        ones_adj = (ones_w >= 4'd5) ? ones_w + 4'd3 : ones_w;
    end

    // Conversion FSM: capture on change, BW shift steps, then load the display registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            force_q    <= 1'b1;
            valid_q    <= 1'b0;
            last_q     <= '0;
            shift_q    <= '0;
            ovf_pend_q <= 1'b0;
            bit_q      <= '0;
            tens_w     <= '0;
            ones_w     <= '0;
            tens_q     <= '0;
            ones_q     <= '0;
            ovf_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (value_i != last_q || force_q) begin
                        shift_q    <= value_i;
                        last_q     <= value_i;
                        ovf_pend_q <= value_ovf;
                        force_q    <= 1'b0;
                        bit_q      <= '0;
                        tens_w     <= '0;
                        ones_w     <= '0;
                        state_q    <= SHIFT;
                    end
                end
                SHIFT: begin
                    tens_w  <= {tens_adj[2:0], ones_adj[3]};
                    ones_w  <= {ones_adj[2:0], shift_q[BW-1]};
                    shift_q <= {shift_q[BW-2:0], 1'b0};
                    if (bit_q == BIT_LAST) begin
                        state_q <= LOAD;
                    end else begin
                        bit_q <= bit_q + CW'(1);
                    end
                end
                LOAD: begin
                    tens_q  <= tens_w;
                    ones_q  <= ones_w;
                    ovf_q   <= ovf_pend_q;
                    valid_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Glyph for the slot currently selected by the multiplex phase
    always_comb begin
        if (ovf_q) begin
            slot_glyph = DASH;
        end else if (phase_q) begin
            slot_glyph = (tens_q == 4'd0) ? BLANK : glyph(tens_q);
        end else begin
            slot_glyph = glyph(ones_q);
        end
    end

    // Refresh counter: flips the digit phase every MUX_DIV cycles
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ref_q   <= '0;
            phase_q <= 1'b0;
        end else if (ref_q == REF_LAST) begin
            ref_q   <= '0;
            phase_q <= ~phase_q;
        end else begin
            ref_q <= ref_q + RW'(1);
        end
    end

    // Registered segment and digit-enable drive, dark until the first conversion lands
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            seg_q <= '0;
            dig_q <= '0;
        end else begin
            seg_q <= valid_q ? slot_glyph : BLANK;
            dig_q <= valid_q ? (phase_q ? 2'b10 : 2'b01) : 2'b00;
        end
    end

    assign seg_o     = seg_q;
    assign dig_sel_o = dig_q;
    assign ovf_o     = ovf_q;
    assign busy_o    = (state_q != IDLE);

endmodule

// File: tb/tb_score_display.sv
// Testbench for score_display: table of display vectors, hand-written
// multi-cycle sequences and random stimulus, all checked cycle by cycle
// against a transaction-level reference model.
module tb_score_display;

    localparam int unsigned BW      = 7;
    localparam int unsigned MUX_DIV = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [BW-1:0] value;
    logic [6:0]    seg;
    logic [1:0]    dig;
    logic          ovf;
    logic          busy;

    int errors = 0;
    int checks = 0;

    // reference model state
    int         m_ticks;
    int         m_busy_left;
    int         m_last;
    int         m_conv;
    int         m_disp;
    bit         m_force;
    bit         m_valid;
    bit         m_ovf;
    logic [6:0] exp_seg;
    logic [1:0] exp_dig;
    logic       exp_ovf;
    logic       exp_busy;

    typedef struct {
        int val;
        int ones;
        int tens;
        int ovf;
    } vec_t;
    vec_t tbl[11];

    score_display #(.BW(BW), .MUX_DIV(MUX_DIV)) dut (
        .clk_i    (clk),
        .rst_n_i  (rst_n),
        .value_i  (value),
        .seg_o    (seg),
        .dig_sel_o(dig),
        .ovf_o    (ovf),
        .busy_o   (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] digit_glyph(input int d);
        case (d)
            0: return 7'h3F;
            1: return 7'h06;
            2: return 7'h5B;
            3: return 7'h4F;
            4: return 7'h66;
            5: return 7'h6D;
            6: return 7'h7D;
            7: return 7'h07;
            8: return 7'h7F;
            9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    task automatic model_reset();
        m_ticks     = 0;
        m_busy_left = 0;
        m_last      = 0;
        m_conv      = 0;
        m_disp      = 0;
        m_force     = 1'b1;
        m_valid     = 1'b0;
        m_ovf       = 1'b0;
        exp_seg     = '0;
        exp_dig     = '0;
        exp_ovf     = 1'b0;
        exp_busy    = 1'b0;
    endtask

    // one clock edge of the display as seen from outside: outputs show the
    // state held before the edge, then the conversion timeline advances
    task automatic model_step(input int v);
        int phase;
        phase = (m_ticks / MUX_DIV) % 2;
        m_ticks++;
        if (!m_valid) begin
            exp_seg = 7'h00;
            exp_dig = 2'b00;
        end else begin
            exp_dig = phase ? 2'b10 : 2'b01;
            if (m_ovf)
                exp_seg = 7'h40;
            else if (phase == 1)
                exp_seg = (m_disp / 10 == 0) ? 7'h00 : digit_glyph(m_disp / 10);
            else
                exp_seg = digit_glyph(m_disp % 10);
        end
        if (m_busy_left > 0) begin
            m_busy_left--;
            if (m_busy_left == 0) begin
                m_disp  = m_conv;
                m_ovf   = (m_conv > 99);
                m_valid = 1'b1;
            end
        end else if (v != m_last || m_force) begin
            m_conv      = v;
            m_last      = v;
            m_force     = 1'b0;
            m_busy_left = BW + 1;
        end
        exp_busy = (m_busy_left > 0);
        exp_ovf  = m_ovf;
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step(int'(value));
        @(negedge clk);
        check("cycle{seg,dig,ovf,busy}", int'({seg, dig, ovf, busy}),
              int'({exp_seg, exp_dig, exp_ovf, exp_busy}));
    endtask

    task automatic settle();
        int n;
        n = 0;
        while (!(m_busy_left == 0 && m_last == int'(value) && !m_force) && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) begin
            errors++;
            $display("FAIL settle: got no idle after %0d cycles, want idle", n);
        end
        tick();
    endtask

    task automatic read_slots(output int ones, output int tens);
        ones = -1;
        tens = -1;
        for (int i = 0; i < 2 * MUX_DIV + 1; i++) begin
            tick();
            if (dig == 2'b01) ones = int'(seg);
            if (dig == 2'b10) tens = int'(seg);
        end
    endtask

    initial begin
        int o, t, n, cnt, rises, len;
        bit prev, saw11, first;
        logic [1:0] cur;

        tbl[0]  = '{0,   'h3F, 'h00, 0};
        tbl[1]  = '{42,  'h5B, 'h66, 0};
        tbl[2]  = '{99,  'h6F, 'h6F, 0};
        tbl[3]  = '{100, 'h40, 'h40, 1};
        tbl[4]  = '{7,   'h07, 'h00, 0};
        tbl[5]  = '{55,  'h6D, 'h6D, 0};
        tbl[6]  = '{127, 'h40, 'h40, 1};
        tbl[7]  = '{10,  'h3F, 'h06, 0};
        tbl[8]  = '{5,   'h6D, 'h00, 0};
        tbl[9]  = '{68,  'h7F, 'h7D, 0};
        tbl[10] = '{81,  'h06, 'h7F, 0};

        // reset with value 0, then first conversion forced after release
        rst_n = 1'b0;
        value = '0;
        model_reset();
        repeat (3) tick();
        check("reset_outputs", int'({seg, dig, ovf, busy}), 0);
        rst_n = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (dig == 2'b00 && n < 50);
        check("first_visible_edge", n, 10);
        read_slots(o, t);
        check("zero_ones", o, 'h3F);
        check("zero_tens_blank", t, 'h00);

        // display vectors
        for (int i = 0; i < 11; i++) begin
            value = BW'(tbl[i].val);
            settle();
            read_slots(o, t);
            check($sformatf("tbl%0d_ones", tbl[i].val), o, tbl[i].ones);
            check($sformatf("tbl%0d_tens", tbl[i].val), t, tbl[i].tens);
            check($sformatf("tbl%0d_ovf", tbl[i].val), int'(ovf), tbl[i].ovf);
        end

        // busy length for one conversion
        value = 7'd42;
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (busy) cnt++;
        end
        check("busy_cycles_42", cnt, 8);

        // counter burst 10 -> 11 -> 12 on consecutive cycles
        value = 7'd3;
        settle();
        prev  = 1'b0;
        rises = 0;
        saw11 = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (i == 0) value = 7'd10;
            if (i == 1) value = 7'd11;
            if (i == 2) value = 7'd12;
            tick();
            if (busy && !prev) rises++;
            prev = busy;
            if (dig == 2'b01 && seg == 7'h06) saw11 = 1'b1;
        end
        check("burst_conversions", rises, 2);
        check("burst_11_shown", int'(saw11), 0);
        read_slots(o, t);
        check("burst_ones", o, 'h5B);
        check("burst_tens", t, 'h06);

        // asynchronous reset in the middle of a conversion
        value = 7'd55;
        tick();
        tick();
        tick();
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", int'({seg, dig, ovf, busy}), 0);
        model_reset();
        tick();
        tick();
        rst_n = 1'b1;
        settle();
        read_slots(o, t);
        check("restart_ones", o, 'h6D);
        check("restart_tens", t, 'h6D);

        // steady value: no conversions, exact slot lengths
        cnt   = 0;
        first = 1'b1;
        cur   = dig;
        len   = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (busy) cnt++;
            if (dig == cur) begin
                len++;
            end else begin
                if (!first) check("slot_len", len, MUX_DIV);
                first = 1'b0;
                cur   = dig;
                len   = 1;
            end
        end
        check("steady_busy", cnt, 0);

        // random score traffic against the model
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) == 0) value = BW'($urandom_range(0, 127));
            tick();
        end
        settle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/score_display.md
# score_display

Two-digit seven-segment display driver for the scoreboard, directly downstream of the up/down score counter. It accepts the counter's binary value (0–99). When the value changes, it converts it to two BCD digits with a sequential shift-add-3 (double-dabble) engine, then drives a time-multiplexed two-digit common display. Values above 99 are flagged and shown as "--".

## Interface
- BW, 7, width of the binary input value; legal range 4..10.
- MUX_DIV, 1000, clock cycles per digit slot in the display multiplex; must be ≥ 2.

- clk_i  input  1  system clock, rising-edge active.
- rst_n_i  input  1  reset; asynchronous, active-low.
- value_i  input  BW  binary score from the counter, unsigned; may change at any cycle.
- seg_o  output  7  segment drive {g,f,e,d,c,b,a}, active-high, registered.
- dig_sel_o  output  2  digit enable, active-high one-hot; bit0 = ones, bit1 = tens; registered.
- ovf_o  output  1  high while the displayed value is > 99.
- busy_o  output  1  high while a conversion is in progress (states SHIFT and LOAD).

## Operation
- Glyphs as {g..a} hex: digits 0–9 = 3F, 06, 5B, 4F, 66, 6D, 7D, 07, 7F, 6F.
  - Dash = 40.
  - Blank = 00.
- FSM states: IDLE, SHIFT, LOAD.
- IDLE → SHIFT on an edge where value_i ≠ last_q, or force_q = 1.
  - On that edge: shift_q ← value_i, last_q ← value_i, ovf_pend ← (value_i > 99), force_q ← 0, bit counter ← 0.
- SHIFT: each cycle, for each 4-bit BCD nibble (tens, ones), add 3 if the nibble is ≥ 5. Then shift {tens, ones, shift_q} left by one.
  - SHIFT runs for exactly BW cycles, then goes to LOAD.
  - If ovf_pend = 1, the BCD result is don't-care.
- LOAD: one cycle. Then return to IDLE.
  - tens_q, ones_q, ovf_q ← results.
  - valid_q ← 1.
- value_i changes during SHIFT or LOAD are ignored. After returning to IDLE, the compare against last_q starts a new conversion, so the final value is always displayed.
- Leading-zero blanking: when tens_q = 0 and ovf_q = 0, the tens slot shows blank (00).
- Overflow: while ovf_q = 1, both slots show dash (40) and ovf_o = 1.
- Multiplex:
  - The refresh counter counts 0..MUX_DIV-1 and wraps.
  - phase_q toggles on every wrap.
  - phase 0 = ones slot, phase 1 = tens slot.
- Output registers, updated every cycle:
  - dig_sel_o = 01 (phase 0) or 10 (phase 1) when valid_q = 1; otherwise 00.
  - seg_o = glyph for the current slot; 00 when valid_q = 0.
- Reset (asynchronous, any state, including mid-conversion):
  - FSM → IDLE; force_q ← 1; valid_q ← 0.
  - tens_q, ones_q, last_q, shift_q, refresh counter, phase_q ← 0.
  - A fresh conversion therefore starts on the first edge after release, even when value_i = 0.

## Timing
- Reset values of outputs: seg_o = 00, dig_sel_o = 00, ovf_o = 0, busy_o = 0.
- Value captured at edge k (IDLE). busy_o is high from edge k through edge k+BW+1 (SHIFT and LOAD).
- Display registers update at edge k+BW+1. seg_o and dig_sel_o reflect the new value from edge k+BW+2.
  - For BW = 7: capture to visible = 9 edges.
  - ovf_o follows ovf_q, so it rises at edge k+BW+1.
- Back-to-back changes: the earliest next capture is edge k+BW+2, the first IDLE edge.
- Digit slot length = MUX_DIV cycles exactly. The first slot after reset is ones.
- No handshake to the counter; value_i is sampled only in IDLE.

## Test plan
- Reset with value_i = 0, release → 9 edges later: dig_sel_o alternates 01 / 10 every MUX_DIV cycles (MUX_DIV = 4 in the bench). Ones slot seg_o = 3F; tens slot seg_o = 00 (blanked). Before that: seg_o = 00, dig_sel_o = 00.
- value_i = 42 in IDLE → busy_o high for 8 cycles. Then ones slot = 5B, tens slot = 66, ovf_o = 0.
- value_i = 99 then 100 → 99 shows 6F / 6F. After 100 converts: ovf_o = 1, both slots = 40. Return to 7 → ovf_o = 0, ones = 07, tens = 00.
- value_i 10 → 11 → 12 on consecutive cycles (counter burst) → conversion of 10 completes, then one conversion of 12. Final display is ones = 5B, tens = 06; 11 is never displayed.
- rst_n_i pulsed low at cycle 3 of SHIFT with value_i = 55 → outputs go to reset values immediately (asynchronously). After release, conversion restarts and displays 6D / 6D.
- value_i held constant for 200 cycles after conversion → busy_o stays 0 and no new conversion occurs. Slot timing is exactly MUX_DIV cycles per digit.
